// File: rtl/unaligned_line_reader.sv
// Read-side byte realigner for the 128-bit line RAM: returns a word whose byte 0 is the requested byte.
// Define UNALIGNED_SPLIT_EN to fetch and merge two lines for nonzero offsets; otherwise one line is rotated.
module unaligned_line_reader #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 128,
  parameter int OFF_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W+OFF_W-1:0] req_addr,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    busy
);

`ifdef UNALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, RESP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     line_q;
  logic [OFF_W-1:0]      off_q;
  logic [OFF_W+2:0]      shift_amt;
  logic [2*DATA_W-1:0]   src;
  logic [DATA_W-1:0]     realigned;
  logic                  split_now;

  assign shift_amt = {off_q, 3'b000};
  assign split_now = SPLIT_EN && (off_q != '0);

  // Doubling a single line turns the right shift into a circular rotate; in CAP the
  // low half is the first line so the shift pulls bytes across the line boundary.
`ifdef UNALIGNED_SPLIT_EN
  logic [DATA_W-1:0] l0;
  assign src = (state == CAP) ? {rd_data, l0} : {rd_data, rd_data};
`else
  assign src = {rd_data, rd_data};
`endif

  assign realigned = DATA_W'(src >> shift_amt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      line_q    <= '0;
      off_q     <= '0;
      resp_data <= '0;
`ifdef UNALIGNED_SPLIT_EN
      l0        <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_q <= req_addr[ADDR_W+OFF_W-1:OFF_W];
            off_q  <= req_addr[OFF_W-1:0];
          end
        end
        RD1: begin
`ifdef UNALIGNED_SPLIT_EN
          l0 <= rd_data;
`endif
          if (!split_now) resp_data <= realigned;
        end
        CAP:     resp_data <= realigned;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) state_nxt = RD0;
      end
      RD0: begin
        rd_en     = 1'b1;
        rd_addr   = line_q;
        state_nxt = RD1;
      end
      RD1: begin
        if (split_now) begin
          rd_en     = 1'b1;
          rd_addr   = line_q + ADDR_W'(1);
          state_nxt = CAP;
        end else begin
          state_nxt = RESP;
        end
      end
      CAP:  state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
